// File: rtl/attn_head_sched_if.sv
// Handshake bundle between the attention-head scheduler, its host and the
// per-head attention controller it launches.
interface attn_head_sched_if #(
  parameter int NUM_HEADS = 4,
  parameter int NUM_TILES = 8
);
  localparam int HW  = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
  localparam int TW  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int HCW = $clog2(NUM_HEADS + 1);
  localparam int TCW = $clog2(NUM_TILES + 1);

  logic           start;
  logic           abort;
  logic [HCW-1:0] cfg_heads;
  logic [TCW-1:0] cfg_tiles;
  logic           head_start;
  logic [HW-1:0]  head_idx;
  logic [TW-1:0]  tile_idx;
  logic           head_done;
  logic           busy;
  logic           done;
  logic           err;
  logic [2:0]     debug_state;

  // master: host plus per-head controller; slave: the scheduler itself
  modport master (
    output start, abort, cfg_heads, cfg_tiles, head_done,
    input  head_start, head_idx, tile_idx, busy, done, err, debug_state
  );

  modport slave (
    input  start, abort, cfg_heads, cfg_tiles, head_done,
    output head_start, head_idx, tile_idx, busy, done, err, debug_state
  );
endinterface

// File: rtl/attn_head_sched.sv
// Sequences heads x tiles attention jobs, one head_start per job, tile-major
// within each head, with a watchdog on every head_done wait.
module attn_head_sched #(
  parameter int NUM_HEADS = 4,
  parameter int NUM_TILES = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic             clk,
  input  logic             rst,
  attn_head_sched_if.slave bus
);
  localparam int HW  = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
  localparam int TW  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int HCW = $clog2(NUM_HEADS + 1);
  localparam int TCW = $clog2(NUM_TILES + 1);
  localparam int WW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t         state_reg, state_next;
  logic [HCW-1:0] heads_reg;
  logic [TCW-1:0] tiles_reg;
  logic [HW-1:0]  head_idx_reg;
  logic [TW-1:0]  tile_idx_reg;
  logic [WW-1:0]  wd_reg;

  logic [HCW-1:0] heads_clamped;
  logic [TCW-1:0] tiles_clamped;
  logic           last_tile;
  logic           last_head;
  logic           wd_at_limit;
  logic           abort_hit;

  // Zero or out-of-range requests mean "use the full configured size".
  assign heads_clamped = (bus.cfg_heads == '0 || bus.cfg_heads > HCW'(NUM_HEADS))
                         ? HCW'(NUM_HEADS) : bus.cfg_heads;
  assign tiles_clamped = (bus.cfg_tiles == '0 || bus.cfg_tiles > TCW'(NUM_TILES))
                         ? TCW'(NUM_TILES) : bus.cfg_tiles;

  assign last_tile   = (TCW'(tile_idx_reg) == tiles_reg - TCW'(1));
  assign last_head   = (HCW'(head_idx_reg) == heads_reg - HCW'(1));
  assign wd_at_limit = (wd_reg == WW'(TIMEOUT));
  assign abort_hit   = bus.abort && (state_reg != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = S_IDLE;
    if (!abort_hit) begin
      case (state_reg)
        S_IDLE:   state_next = bus.start ? S_LAUNCH : S_IDLE;
        S_LAUNCH: state_next = S_WAIT;
        // head_done wins over an expiring watchdog in the same cycle
        S_WAIT: begin
          if (bus.head_done) begin
            state_next = S_NEXT;
          end else if (wd_at_limit) begin
            state_next = S_ERROR;
          end else begin
            state_next = S_WAIT;
          end
        end
        S_NEXT:   state_next = (last_tile && last_head) ? S_FINISH : S_LAUNCH;
        S_FINISH: state_next = S_IDLE;
        S_ERROR:  state_next = bus.start ? S_IDLE : S_ERROR;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Job counters, latched configuration and watchdog; an abort freezes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      heads_reg    <= '0;
      tiles_reg    <= '0;
      head_idx_reg <= '0;
      tile_idx_reg <= '0;
      wd_reg       <= '0;
    end else if (!abort_hit) begin
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            heads_reg    <= heads_clamped;
            tiles_reg    <= tiles_clamped;
            head_idx_reg <= '0;
            tile_idx_reg <= '0;
            wd_reg       <= '0;
          end
        end
        S_LAUNCH: wd_reg <= '0;
        S_WAIT: begin
          if (!bus.head_done && !wd_at_limit) begin
            wd_reg <= wd_reg + WW'(1);
          end
        end
        S_NEXT: begin
          if (!last_tile) begin
            tile_idx_reg <= tile_idx_reg + TW'(1);
          end else if (!last_head) begin
            tile_idx_reg <= '0;
            head_idx_reg <= head_idx_reg + HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.head_start  = (state_reg == S_LAUNCH);
    bus.done        = (state_reg == S_FINISH);
    bus.err         = (state_reg == S_ERROR);
    bus.busy        = (state_reg != S_IDLE) && (state_reg != S_ERROR);
    bus.debug_state = state_reg;
    bus.head_idx    = head_idx_reg;
    bus.tile_idx    = tile_idx_reg;
  end
endmodule

// File: tb/tb_attn_head_sched.sv
// Self-checking bench for attn_head_sched: table-driven and randomized runs
// against a launch-order model, plus watchdog, collision, abort and reset cases.
`timescale 1ns/1ps
module tb_attn_head_sched;
  localparam int NH = 4;
  localparam int NT = 8;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  attn_head_sched_if #(.NUM_HEADS(NH), .NUM_TILES(NT)) bus ();

  attn_head_sched #(.NUM_HEADS(NH), .NUM_TILES(NT), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int ch;
    int ct;
    int dly;
    bit rnd;
    int exp_n;
    int exp_lh;
    int exp_lt;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int eff(input int v, input int mx);
    return (v == 0 || v > mx) ? mx : v;
  endfunction

  // One complete run: model is the plain nested-loop job list; timing rules are
  // first launch right after start, next launch two cycles after head_done.
  task automatic run_job(input int ch, input int ct, input int dly, input bit rnd,
                         output int nl, output int lh, output int lt);
    int eh[$];
    int et[$];
    int h_eff, t_eff, k, next_l, launch_at, hd_at, cur_d;
    bit done_seen;
    h_eff = eff(ch, NH);
    t_eff = eff(ct, NT);
    for (int h = 0; h < h_eff; h++)
      for (int t = 0; t < t_eff; t++) begin
        eh.push_back(h);
        et.push_back(t);
      end
    nl = 0; lh = -1; lt = -1;
    bus.cfg_heads = 3'(ch);
    bus.cfg_tiles = 4'(ct);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0; next_l = 0; launch_at = -1; hd_at = -1; cur_d = dly; done_seen = 1'b0;
    while (!done_seen && k < 3000) begin
      bus.head_done = 1'b0;
      if (bus.head_start) begin
        chk("launch_time", k, next_l);
        chk("busy_in_run", int'(bus.busy), 1);
        if (eh.size() == 0) begin
          chk("extra_launch", nl + 1, h_eff * t_eff);
        end else begin
          chk("head_idx", int'(bus.head_idx), eh.pop_front());
          chk("tile_idx", int'(bus.tile_idx), et.pop_front());
        end
        nl++;
        lh = int'(bus.head_idx);
        lt = int'(bus.tile_idx);
        launch_at = k;
        cur_d = rnd ? int'($urandom_range(1, 6)) : dly;
        if (rnd && $urandom_range(0, 1) == 1) bus.head_done = 1'b1;
      end
      if (bus.done) begin
        chk("done_time", k, hd_at + 2);
        chk("launches_left", eh.size(), 0);
        done_seen = 1'b1;
      end else if (launch_at >= 0 && k == launch_at + cur_d) begin
        bus.head_done = 1'b1;
        hd_at = k;
        next_l = k + 2;
      end else if (rnd && hd_at >= 0 && k == hd_at + 1 && $urandom_range(0, 1) == 1) begin
        bus.head_done = 1'b1;
      end
      bus.start = (!done_seen && rnd) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    bus.head_done = 1'b0;
    chk("run_completed", int'(done_seen), 1);
    chk("busy_after_done", int'(bus.busy), 0);
    chk("done_one_cycle", int'(bus.done), 0);
    chk("final_head_hold", int'(bus.head_idx), h_eff - 1);
    chk("final_tile_hold", int'(bus.tile_idx), t_eff - 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    int nl, lh, lt, k, nlc, la, seen;
    bit aborted;

    tbl[0] = '{2, 3, 4, 1'b0, 6, 1, 2};
    tbl[1] = '{0, 9, 1, 1'b0, 32, 3, 7};
    tbl[2] = '{1, 1, 1, 1'b1, 1, 0, 0};
    tbl[3] = '{5, 0, 2, 1'b1, 32, 3, 7};
    tbl[4] = '{3, 2, 1, 1'b1, 6, 2, 1};
    tbl[5] = '{4, 15, 3, 1'b0, 32, 3, 7};

    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.head_done = 1'b0;
    bus.cfg_heads = '0; bus.cfg_tiles = '0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    chk("rst_state", int'(bus.debug_state), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_head_start", int'(bus.head_start), 0);
    chk("rst_err_done", int'({bus.err, bus.done}), 0);
    chk("rst_idx", int'({bus.head_idx, bus.tile_idx}), 0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    $display("reset: state=%0d busy=%0d", bus.debug_state, bus.busy);

    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i].ch, tbl[i].ct, tbl[i].dly, tbl[i].rnd, nl, lh, lt);
      chk("tbl_launches", nl, tbl[i].exp_n);
      chk("tbl_last_head", lh, tbl[i].exp_lh);
      chk("tbl_last_tile", lt, tbl[i].exp_lt);
      $display("vec %0d: cfg=(%0d,%0d) launches=%0d last=(%0d,%0d)",
               i, tbl[i].ch, tbl[i].ct, nl, lh, lt);
    end

    for (int i = 0; i < 6; i++) begin
      int ch, ct;
      ch = int'($urandom_range(0, 7));
      ct = int'($urandom_range(0, 15));
      run_job(ch, ct, 1, 1'b1, nl, lh, lt);
      chk("rand_launches", nl, eff(ch, NH) * eff(ct, NT));
      $display("rand %0d: cfg=(%0d,%0d) launches=%0d", i, ch, ct, nl);
    end

    // Watchdog: 16 waiting cycles (count 0..15) then ERROR.
    bus.cfg_heads = 3'd1; bus.cfg_tiles = 4'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("wd_launch", int'(bus.head_start), 1);
    for (int i = 1; i <= 16; i++) @(negedge clk);
    chk("wd_not_yet", int'(bus.err), 0);
    chk("wd_still_wait", int'(bus.debug_state), 2);
    @(negedge clk);
    chk("wd_err", int'(bus.err), 1);
    chk("wd_busy", int'(bus.busy), 0);
    chk("wd_state", int'(bus.debug_state), 5);
    bus.head_done = 1'b1;
    @(negedge clk);
    bus.head_done = 1'b0;
    chk("err_ignores_done", int'(bus.err), 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("err_clear", int'(bus.err), 0);
    chk("err_to_idle", int'(bus.debug_state), 0);
    @(negedge clk);
    chk("err_no_launch", int'(bus.head_start), 0);
    $display("watchdog: err cleared, state=%0d", bus.debug_state);

    // Collision: head_done on the cycle the watchdog reaches its limit.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i <= 16; i++) @(negedge clk);
    bus.head_done = 1'b1;
    @(negedge clk);
    bus.head_done = 1'b0;
    chk("coll_next", int'(bus.debug_state), 3);
    chk("coll_no_err", int'(bus.err), 0);
    @(negedge clk);
    chk("coll_done", int'(bus.done), 1);
    @(negedge clk);
    $display("collision: state=%0d err=%0d", bus.debug_state, bus.err);

    // Abort during the third job's wait.
    bus.cfg_heads = 3'd2; bus.cfg_tiles = 4'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0; nlc = 0; la = -1; aborted = 1'b0;
    while (!aborted && k < 100) begin
      bus.head_done = 1'b0;
      if (bus.head_start) begin
        nlc++;
        la = k;
      end
      if (nlc == 3 && k == la + 1) begin
        chk("abort_in_wait", int'(bus.debug_state), 2);
        bus.abort = 1'b1;
        aborted = 1'b1;
      end else if (la >= 0 && k == la + 2) begin
        bus.head_done = 1'b1;
      end
      @(negedge clk);
      k++;
    end
    bus.abort = 1'b0;
    bus.head_done = 1'b0;
    chk("abort_reached", int'(aborted), 1);
    chk("abort_idle", int'(bus.debug_state), 0);
    chk("abort_busy", int'(bus.busy), 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      seen += int'(bus.done) + int'(bus.head_start);
      @(negedge clk);
    end
    chk("abort_quiet", seen, 0);
    run_job(1, 2, 1, 1'b0, nl, lh, lt);
    chk("abort_restart", nl, 2);
    $display("abort: restart launches=%0d", nl);

    // Asynchronous reset between clock edges in the middle of a wait.
    bus.cfg_heads = 3'd2; bus.cfg_tiles = 4'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.head_done = 1'b1;
    @(negedge clk);
    bus.head_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("arst_pre_tile", int'(bus.tile_idx), 1);
    chk("arst_pre_wait", int'(bus.debug_state), 2);
    #1 rst = 1'b1;
    #1;
    chk("arst_state", int'(bus.debug_state), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_tile", int'(bus.tile_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.head_done = 1'b1;
    @(negedge clk);
    bus.head_done = 1'b0;
    @(negedge clk);
    chk("arst_idle_hold", int'(bus.debug_state), 0);
    chk("arst_no_done", int'({bus.done, bus.err, bus.head_start}), 0);
    $display("async reset: state=%0d busy=%0d", bus.debug_state, bus.busy);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
